// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine input conditioner.
// Holds the default debounce/jam thresholds and the channel index enum used
// to address the per-channel vectors (quarter, product-1, product-2).
package vend_pkg;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_JAM_CYCLES      = 64;
   localparam int NUM_CH              = 3;

   typedef enum logic [1:0] {
      CH_QUARTER = 2'd0,
      CH_SEL1    = 2'd1,
      CH_SEL2    = 2'd2
   } ch_e;

endpackage

// File: rtl/vend_input_conditioner_debounce.sv
// Purpose : one input channel: 2-flop synchronizer, debounce counter, stable level, rise pulse.
// Latency : raw sampled at edge N -> o_stable/o_rise high after edge N+DEBOUNCE_CYCLES+1.
// Backpr. : none; free-running, o_rise is a single-cycle pulse.
// Ports   : clk, reset (sync, active-low), i_raw (async level), o_stable (debounced level),
//           o_rise (one-cycle pulse on the stable 0->1 flip).
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_stable,
   output logic o_rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // Flip happens on the edge where the counter would have reached DEBOUNCE_CYCLES,
   // so the counter itself never holds that value and cannot wrap.
   localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic          r_stable;
   logic          r_rise;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         if (r_sync2 != r_stable) begin
            if (r_cnt == LAST_CNT) begin
               r_stable <= r_sync2;
               r_cnt    <= '0;
               r_rise   <= r_sync2;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_stable = r_stable;
   assign o_rise   = r_rise;

endmodule

// File: rtl/vend_input_conditioner.sv
// Purpose : debounce coin/button inputs, arbitrate into one-hot request pulses, detect coin jam.
// Latency : raw high at edge N -> pulse after edge N+DEBOUNCE_CYCLES+2 when nothing else pending.
// Backpr. : none; simultaneous requests are queued in pending bits, one pulse per cycle.
// Ports   : clk, reset (sync, active-low), coin_sense/btn1_raw/btn2_raw (async raw inputs),
//           quarter_in/select1/select2 (one-cycle pulses, at most one per cycle), coin_jam (level).
module vend_input_conditioner
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int JAM_CYCLES      = DEF_JAM_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic coin_sense,
   input  logic btn1_raw,
   input  logic btn2_raw,
   output logic quarter_in,
   output logic select1,
   output logic select2,
   output logic coin_jam
);

   localparam int JW = $clog2(JAM_CYCLES + 1);
   localparam logic [JW-1:0] JAM_MAX = JW'(JAM_CYCLES);

   logic [NUM_CH-1:0] w_raw;
   logic [NUM_CH-1:0] w_stable;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_req;
   logic [NUM_CH-1:0] w_gnt;
   logic [NUM_CH-1:0] r_pend;
   logic [NUM_CH-1:0] r_pulse;
   logic [JW-1:0]     r_jam_cnt;
   logic              r_jam;
   logic              w_coin_stable;
   logic              w_unused_stable;

   assign w_raw[CH_QUARTER] = coin_sense;
   assign w_raw[CH_SEL1]    = btn1_raw;
   assign w_raw[CH_SEL2]    = btn2_raw;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk      (clk),
         .reset    (reset),
         .i_raw    (w_raw[g]),
         .o_stable (w_stable[g]),
         .o_rise   (w_rise[g])
      );
   end

   // Button stable levels have no consumer; only the coin level feeds the jam logic.
   assign w_unused_stable = ^w_stable[CH_SEL2:CH_SEL1];
   assign w_coin_stable   = w_stable[CH_QUARTER];

   // A rise arriving this cycle competes immediately, without a pending-bit round trip.
   assign w_req = r_pend | w_rise;

   always_comb begin
      w_gnt = '0;
      if (w_req[CH_QUARTER]) begin
         w_gnt[CH_QUARTER] = 1'b1;
      end else if (w_req[CH_SEL1]) begin
         w_gnt[CH_SEL1] = 1'b1;
      end else if (w_req[CH_SEL2]) begin
         w_gnt[CH_SEL2] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pend  <= '0;
         r_pulse <= '0;
      end else begin
         r_pend  <= w_req & ~w_gnt;
         r_pulse <= w_gnt;
      end
   end

   // Jam timer starts on the cycle after the coin's rise, i.e. it measures how long
   // the coin stays in the slot once it has been reported. Saturates at JAM_CYCLES.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_jam_cnt <= '0;
         r_jam     <= 1'b0;
      end else begin
         if (!w_coin_stable) begin
            r_jam_cnt <= '0;
         end else if (!w_rise[CH_QUARTER] && (r_jam_cnt != JAM_MAX)) begin
            r_jam_cnt <= r_jam_cnt + JW'(1);
         end
         r_jam <= w_coin_stable && (r_jam_cnt == JAM_MAX);
      end
   end

   assign quarter_in = r_pulse[CH_QUARTER];
   assign select1    = r_pulse[CH_SEL1];
   assign select2    = r_pulse[CH_SEL2];
   assign coin_jam   = r_jam;

endmodule

// File: tb/tb_vend_input_conditioner.sv
// Directed bench for vend_input_conditioner with DEBOUNCE_CYCLES=4, JAM_CYCLES=64.
// Inputs change at the falling edge; rel is the index of the most recent rising edge,
// so an input set when rel==N-1 is first sampled at edge N, and outputs observed when
// rel==K are the values in the cycle following edge K.
module tb_vend_input_conditioner;

   logic clk = 1'b0;
   logic reset;
   logic coin_sense;
   logic btn1_raw;
   logic btn2_raw;
   logic quarter_in;
   logic select1;
   logic select2;
   logic coin_jam;

   int n_assert = 0;
   int n_fail   = 0;
   int rel      = 0;

   int q_cnt, q_at, s1_cnt, s1_at, s2_cnt, s2_at;
   int jam_cnt, jam_first, jam_last;

   vend_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .JAM_CYCLES     (64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .coin_sense (coin_sense),
      .btn1_raw   (btn1_raw),
      .btn2_raw   (btn2_raw),
      .quarter_in (quarter_in),
      .select1    (select1),
      .select2    (select2),
      .coin_jam   (coin_jam)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_rec();
      q_cnt = 0;  q_at = -1;
      s1_cnt = 0; s1_at = -1;
      s2_cnt = 0; s2_at = -1;
      jam_cnt = 0; jam_first = -1; jam_last = -1;
   endtask

   task automatic tick();
      @(negedge clk);
      rel++;
      check("onehot", int'($countones({quarter_in, select1, select2}) <= 1), 1);
      if (quarter_in === 1'b1) begin q_cnt++;  q_at  = rel; end
      if (select1    === 1'b1) begin s1_cnt++; s1_at = rel; end
      if (select2    === 1'b1) begin s2_cnt++; s2_at = rel; end
      if (coin_jam   === 1'b1) begin
         jam_cnt++;
         if (jam_first < 0) jam_first = rel;
         jam_last = rel;
      end
   endtask

   task automatic run_to(input int n);
      while (rel < n) tick();
   endtask

   // Leaves reset released at a falling edge; the next rising edge is edge 0.
   task automatic do_reset();
      reset = 1'b0;
      coin_sense = 1'b0;
      btn1_raw = 1'b0;
      btn2_raw = 1'b0;
      tick();
      tick();
      check("rst_outputs", int'({quarter_in, select1, select2, coin_jam}), 0);
      reset = 1'b1;
      rel = -1;
      clear_rec();
   endtask

   initial begin
      reset = 1'b0;
      coin_sense = 1'b0;
      btn1_raw = 1'b0;
      btn2_raw = 1'b0;
      clear_rec();

      // Single coin, 20 cycles: one quarter after edge 16, no jam.
      do_reset();
      run_to(9);  coin_sense = 1'b1;
      run_to(29); coin_sense = 1'b0;
      run_to(60);
      check("coin_q_cnt", q_cnt, 1);
      check("coin_q_at", q_at, 16);
      check("coin_no_jam", jam_cnt, 0);

      // Two 3-cycle bounces on button 1: filtered out.
      do_reset();
      run_to(9);  btn1_raw = 1'b1;
      run_to(12); btn1_raw = 1'b0;
      run_to(14); btn1_raw = 1'b1;
      run_to(17); btn1_raw = 1'b0;
      run_to(40);
      check("glitch_s1_cnt", s1_cnt, 0);

      // All three rise together: serialized by priority on edges 16, 17, 18.
      do_reset();
      run_to(9);
      coin_sense = 1'b1; btn1_raw = 1'b1; btn2_raw = 1'b1;
      run_to(40);
      check("all_q_cnt", q_cnt, 1);
      check("all_q_at", q_at, 16);
      check("all_s1_cnt", s1_cnt, 1);
      check("all_s1_at", s1_at, 17);
      check("all_s2_cnt", s2_cnt, 1);
      check("all_s2_at", s2_at, 18);
      coin_sense = 1'b0; btn1_raw = 1'b0; btn2_raw = 1'b0;

      // Coin held 100 cycles from edge 0: jam window, with a button 1 press during the jam.
      do_reset();
      coin_sense = 1'b1;
      run_to(79); btn1_raw = 1'b1;
      run_to(86);
      check("jam_s1_now", int'(select1), 1);
      check("jam_level_now", int'(coin_jam), 1);
      run_to(89); btn1_raw = 1'b0;
      run_to(99); coin_sense = 1'b0;
      run_to(130);
      check("jam_q_cnt", q_cnt, 1);
      check("jam_q_at", q_at, 6);
      check("jam_first", jam_first, 71);
      check("jam_last", jam_last, 105);
      check("jam_cycles", jam_cnt, 35);
      check("jam_s1_cnt", s1_cnt, 1);
      check("jam_s1_at", s1_at, 86);

      // Reset mid-debounce on button 2, button held across release.
      do_reset();
      run_to(9);  btn2_raw = 1'b1;
      run_to(13); reset = 1'b0;
      run_to(15);
      check("midrst_outputs", int'({quarter_in, select1, select2, coin_jam}), 0);
      check("midrst_s2_before", s2_cnt, 0);
      reset = 1'b1;
      run_to(40);
      check("midrst_s2_cnt", s2_cnt, 1);
      check("midrst_s2_at", s2_at, 22);
      btn2_raw = 1'b0;
      run_to(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vend_input_conditioner.md
VEND_INPUT_CONDITIONER -- requirements
Module: vend_input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized input must differ from its stable value before the stable value flips; legal range 2..255.
REQ-002 Parameter: JAM_CYCLES, 64, consecutive cycles of stable coin-high that declare a jam; must exceed DEBOUNCE_CYCLES.
REQ-003 Port: clk  input  1  clock; all state on rising edge.
REQ-004 Port: reset  input  1  reset, synchronous, active-low.
REQ-005 Port: coin_sense  input  1  raw asynchronous quarter-slot sensor, high while a coin is in the slot.
REQ-006 Port: btn1_raw  input  1  raw asynchronous product-1 button, high while pressed.
REQ-007 Port: btn2_raw  input  1  raw asynchronous product-2 button, high while pressed.
REQ-008 Port: quarter_in  output  1  one-cycle pulse, one accepted quarter; drives the vending controller.
REQ-009 Port: select1  output  1  one-cycle pulse, product-1 request.
REQ-010 Port: select2  output  1  one-cycle pulse, product-2 request.
REQ-011 Port: coin_jam  output  1  level, coin slot jammed.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Per channel: counter increments while synchronized value != stable value, clears to 0 when equal; stable value flips and counter clears on the cycle the counter would reach DEBOUNCE_CYCLES.
REQ-014 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); no wrap permitted.
REQ-015 A 0->1 transition of a channel's stable value SHALL set that channel's pending bit; 1->0 transitions SHALL produce nothing.
REQ-016 Arbiter: each cycle, if any pending bit (including one being set this cycle) is set, exactly one registered output pulses, priority quarter_in > select1 > select2, and that pending bit clears; others stay pending.
REQ-017 At most one of quarter_in/select1/select2 SHALL be high in any cycle; each pulse lasts exactly one cycle.
REQ-018 Latency: raw input first sampled high at edge N and held, no competing pending bits -> output pulse high in the cycle following edge N+DEBOUNCE_CYCLES+2.
REQ-019 Glitches shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no pulse.
REQ-020 Simultaneous stable rises on all three channels SHALL yield quarter_in, select1, select2 in three consecutive cycles.
REQ-021 A pending bit already set when a new rise on the same channel arrives SHALL remain set (merge); debounce timing guarantees this cannot occur when DEBOUNCE_CYCLES >= 2.
REQ-022 Jam counter counts cycles with coin stable value high, saturates at JAM_CYCLES; coin_jam asserts the cycle after the count reaches JAM_CYCLES.
REQ-023 coin_jam SHALL deassert the cycle after coin stable value falls; the original quarter pulse is not retracted.
REQ-024 While coin_jam is high, select1/select2 processing SHALL continue unaffected.

Reset
REQ-025 While reset is low at a clock edge: synchronizers, stable values, counters, pending bits, jam counter cleared to 0; quarter_in, select1, select2, coin_jam low.
REQ-026 Reset mid-operation SHALL discard all pending pulses and partial debounce counts.
REQ-027 An input held high across reset release SHALL produce exactly one pulse, timed per REQ-018 from the first post-reset edge.

Structure
REQ-028 Shared package vend_pkg SHALL hold DEBOUNCE_CYCLES and JAM_CYCLES defaults and a channel-index enum (CH_QUARTER=0, CH_SEL1=1, CH_SEL2=2).
REQ-029 Sub-module debounce_channel (synchronizer, counter, stable value, rise detect) SHALL be instantiated three times; arbiter and jam logic live in the top.

Verification (DEBOUNCE_CYCLES=4, JAM_CYCLES=64)
REQ-030 coin_sense high for 20 cycles from edge 10 -> single quarter_in pulse in cycle after edge 16; coin_jam never asserts.
REQ-031 btn1_raw high for 3 cycles, low, high for 3 cycles -> no select1 pulse.
REQ-032 All three raw inputs rise at edge 10 and hold -> quarter_in, select1, select2 after edges 16, 17, 18 respectively, never overlapping.
REQ-033 coin_sense held high 100 cycles from edge 0 -> one quarter_in after edge 6; coin_jam high from cycle after edge 71 until cycle after coin stable falls.
REQ-034 btn2_raw rises at edge 10, reset low at edge 14 for 2 cycles, btn2 held -> no pulse before reset; one select2 after edge 22.
REQ-035 Bench SHALL assert one-hot-or-zero on the three pulse outputs every cycle.
